// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: WIDTH-bit add/sub cut into STAGES slices of 4-bit CLA groups.
// Define CLA_ADDSUB_SAT_EN to add the sat port (signed saturation on overflow).
module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
`ifdef CLA_ADDSUB_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int NG    = SLICE / 4;

    // Bit carries into a 4-bit group, fully expanded from the group carry-in.
    function automatic logic [3:0] grp_carry(
        input logic [3:0] p,
        input logic [3:0] g,
        input logic       ci
    );
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0])
             | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    logic              adv;
    logic [STAGES-1:0] vq;
    logic [WIDTH-1:0]  beff;
    logic              c0;
    logic [STAGES-1:0] scout;
    logic [WIDTH-1:0]  wsum;
    logic              amsb;
    logic              bmsb;
    logic              cmsb;
    logic              ovf_c;
    logic [WIDTH-1:0]  res_c;

    assign out_valid = vq[STAGES-1];
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign beff      = b ^ {WIDTH{sub}};
    assign c0        = sub | cin;

    for (genvar j = 0; j < STAGES; j++) begin : g_sl
        localparam int LO = j * SLICE;
        localparam int DL = STAGES - 1 - j;

        logic [SLICE-1:0] sa;
        logic [SLICE-1:0] sb;
        logic [SLICE-1:0] ss;
        logic             ci;
        logic [NG-1:0]    gp;
        logic [NG-1:0]    gg;
        logic [NG:0]      gc;

        if (j == 0) begin : g_in
            assign sa = a[LO +: SLICE];
            assign sb = beff[LO +: SLICE];
            assign ci = c0;
        end else begin : g_skew
            logic [SLICE-1:0] ad [j];
            logic [SLICE-1:0] bd [j];
            logic             cr;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cr <= 1'b0;
                    for (int i = 0; i < j; i++) begin
                        ad[i] <= '0;
                        bd[i] <= '0;
                    end
                end else if (adv) begin
                    cr    <= scout[j-1];
                    ad[0] <= a[LO +: SLICE];
                    bd[0] <= beff[LO +: SLICE];
                    for (int i = 1; i < j; i++) begin
                        ad[i] <= ad[i-1];
                        bd[i] <= bd[i-1];
                    end
                end
            end

            assign sa = ad[j-1];
            assign sb = bd[j-1];
            assign ci = cr;
        end

        always_comb begin
            logic [SLICE-1:0] p;
            logic [SLICE-1:0] g;
            logic             t;
            logic             pp;
            p  = sa ^ sb;
            g  = sa & sb;
            t  = 1'b0;
            pp = 1'b0;
            gp = '0;
            gg = '0;
            gc = '0;
            ss = '0;
            for (int i = 0; i < NG; i++) begin
                gp[i] = &p[4*i +: 4];
                gg[i] = g[4*i+3]
                      | (p[4*i+3] & g[4*i+2])
                      | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                      | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
            end
            // Each group carry is a flat sum of products over lower groups.
            gc[0] = ci;
            for (int i = 1; i <= NG; i++) begin
                t  = gg[i-1];
                pp = gp[i-1];
                for (int m = i - 2; m >= 0; m--) begin
                    t  = t | (gg[m] & pp);
                    pp = pp & gp[m];
                end
                gc[i] = t | (pp & ci);
            end
            for (int i = 0; i < NG; i++) begin
                ss[4*i +: 4] = p[4*i +: 4]
                             ^ grp_carry(p[4*i +: 4], g[4*i +: 4], gc[i]);
            end
        end

        assign scout[j] = gc[NG];

        if (DL == 0) begin : g_last
            assign wsum[LO +: SLICE] = ss;
            assign amsb = sa[SLICE-1];
            assign bmsb = sb[SLICE-1];
        end else begin : g_desk
            logic [SLICE-1:0] rd [DL];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DL; i++) rd[i] <= '0;
                end else if (adv) begin
                    rd[0] <= ss;
                    for (int i = 1; i < DL; i++) rd[i] <= rd[i-1];
                end
            end

            assign wsum[LO +: SLICE] = rd[DL-1];
        end
    end

    assign cmsb  = amsb ^ bmsb ^ wsum[WIDTH-1];
    assign ovf_c = cmsb ^ scout[STAGES-1];

`ifdef CLA_ADDSUB_SAT_EN
    logic sat_f;

    if (STAGES == 1) begin : g_sat0
        assign sat_f = sat;
    end else begin : g_satd
        logic [STAGES-2:0] sd;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sd <= '0;
            end else if (adv) begin
                sd[0] <= sat;
                for (int i = 1; i < STAGES - 1; i++) sd[i] <= sd[i-1];
            end
        end

        assign sat_f = sd[STAGES-2];
    end

    // On overflow both operand MSBs agree, so A's MSB gives the direction.
    always_comb begin
        res_c = wsum;
        if (sat_f && ovf_c) begin
            res_c = amsb ? {1'b1, {(WIDTH-1){1'b0}}}
                         : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign res_c = wsum;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vq   <= '0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (adv) begin
            vq[0] <= in_valid;
            for (int i = 1; i < STAGES; i++) vq[i] <= vq[i-1];
            sum  <= res_c;
            cout <= scout[STAGES-1];
            ovf  <= ovf_c;
            zero <= ~|res_c;
        end
    end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb_pipelined_cla_addsub: scoreboard bench; results modelled with 33-bit arithmetic.
// Covers reset, flags, slice-boundary carry, backpressure and mid-flight reset.
module tb_pipelined_cla_addsub;

    localparam int W = 32;
    localparam int S = 2;
`ifdef CLA_ADDSUB_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
        logic [31:0] t;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         sat;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] cyc     = '0;
    bit          lat_chk;
    bit          done;
    exp_t        q[$];

    pipelined_cla_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
`ifdef CLA_ADDSUB_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic ms, input logic mc,
                                   input logic msat);
        exp_t        r;
        logic [31:0] be;
        logic [32:0] f;
        be  = ms ? ~mb : mb;
        f   = {1'b0, ma} + {1'b0, be} + {32'd0, ms | mc};
        r.s = f[31:0];
        r.c = f[32];
        r.o = (ma[31] == be[31]) && (f[31] != ma[31]);
        if (SAT_EN && msat && r.o) r.s = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        r.z = (r.s == 32'd0);
        r.t = '0;
        return r;
    endfunction

    // Scoreboard monitor, sampled mid-cycle.
    initial begin
        exp_t        e;
        bit          pstall;
        logic [34:0] psnap;
        pstall = 1'b0;
        psnap  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pstall = 1'b0;
            end else begin
                chk("rdy", 64'(in_ready), 64'(!out_valid || out_ready));
                if (pstall) begin
                    chk("hold_v", 64'(out_valid), 64'd1);
                    chk("hold_d", 64'({sum, cout, ovf, zero}), 64'(psnap));
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("spur", 64'(out_valid), 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk("sum", 64'(sum), 64'(e.s));
                        chk("cout", 64'(cout), 64'(e.c));
                        chk("ovf", 64'(ovf), 64'(e.o));
                        chk("zero", 64'(zero), 64'(e.z));
                        if (lat_chk) chk("lat", 64'(cyc - e.t), 64'(S));
                    end
                end
                if (in_valid && in_ready) begin
                    e   = model(a, b, sub, cin, sat);
                    e.t = cyc;
                    q.push_back(e);
                end
                pstall = out_valid && !out_ready;
                psnap  = {sum, cout, ovf, zero};
            end
        end
    end

    task automatic send(input logic [31:0] ta, input logic [31:0] tb_,
                        input logic ts, input logic tc, input logic tsat);
        bit acc;
        int n;
        a        = ta;
        b        = tb_;
        sub      = ts;
        cin      = tc;
        sat      = tsat;
        in_valid = 1'b1;
        acc      = 1'b0;
        n        = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("acc_to", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        while (q.size() != 0 && n < lim) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            chk("drain", 64'(q.size()), 64'd0);
            q.delete();
        end
    endtask

    task automatic single(input logic [31:0] ta, input logic [31:0] tb_,
                          input logic ts, input logic tc, input logic tsat);
        send(ta, tb_, ts, tc, tsat);
        drain(20);
    endtask

    task automatic chk_rst();
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_ir", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        cin       = 1'b0;
        sat       = 1'b0;
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        done      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_rst();
        rst_n = 1'b1;

        single(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        single(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        single(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        single(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 1'b0);
        single(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 1'b0);
        single(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        single(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
        single(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        single(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1, 1'b0);

        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(32'(i), 32'h0000_FFFF, 1'b0, 1'b1, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain(40);

        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send($urandom, $urandom, 1'($urandom_range(1)),
                         1'($urandom_range(1)), 1'($urandom_range(1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain(100);

        lat_chk   = 1'b1;
        out_ready = 1'b0;
        send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        chk_rst();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        single(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_ov", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
